fetch_buffer: RTL

- Small instruction FIFO between the fetch stage (IFU) and the Decode-stage controller/datapath.
- Decouples IFU delivery from Decode stalls.
- Presents InstrD/PCD to Decode, and a NOP bubble when empty.
- Cleared by FlushD, e.g. on branch mispredict, CSR write or fence.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_buffer_ptr.sv | 23 ++
 rtl/fetch_buffer.sv | 114 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch buffer: bubble instruction, entry layout and
// performance counter width.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int unsigned FB_XLEN    = 64;
    localparam int unsigned PERF_CNT_W = 32;

    typedef struct packed {
        logic [31:0]        instr;
        logic [FB_XLEN-1:0] pc;
    } fb_entry_t;

endpackage

// File: rtl/fetch_buffer_ptr.sv
// Wrapping FIFO pointer: async active-low clear, synchronous clear (flush) with
// priority over the increment enable.
module fetch_buffer_ptr #(
    parameter int unsigned PW = 3
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PW'(1);
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction FIFO between IFU and Decode; presents a NOP bubble when empty.
// Optional perf counters (starve / full-offer cycles) under FETCH_BUFFER_PERF_EN.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64,
    parameter logic [31:0] NOP   = NOP_INSTR
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                InstrF,
    input  logic [XLEN-1:0]            PCF,
    input  logic                       InstrValidF,
    output logic                       FetchBufReadyF,
    input  logic                       StallD,
    input  logic                       FlushD,
    output logic [31:0]                InstrD,
    output logic [XLEN-1:0]            PCD,
    output logic                       FetchBufValidD,
    output logic [$clog2(DEPTH):0]     FetchBufCountD
`ifdef FETCH_BUFFER_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]      FetchBufStarveCnt,
    output logic [PERF_CNT_W-1:0]      FetchBufFullCnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        headEntry;
    logic [PW-1:0] rp;
    logic [PW-1:0] wp;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    assign empty = (rp == wp);
    assign full  = (rp[AW-1:0] == wp[AW-1:0]) && (rp[AW] != wp[AW]);

    // Ready depends on pointer state only, so a full buffer refuses a push even
    // when Decode pops in the same cycle.
    assign push = InstrValidF & ~full;
    assign pop  = ~empty & ~StallD;

    fetch_buffer_ptr #(.PW(PW)) u_rp (
        .clk   (clk),
        .reset (reset),
        .clear (FlushD),
        .inc   (pop),
        .ptr   (rp)
    );

    fetch_buffer_ptr #(.PW(PW)) u_wp (
        .clk   (clk),
        .reset (reset),
        .clear (FlushD),
        .inc   (push),
        .ptr   (wp)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp[AW-1:0]] <= '{instr: InstrF, pc: PCF};
        end
    end

    assign headEntry = mem[rp[AW-1:0]];

    always_comb begin
        InstrD = NOP;
        PCD    = '0;
        if (!empty) begin
            InstrD = headEntry.instr;
            PCD    = headEntry.pc;
        end
    end

    assign FetchBufValidD = ~empty;
    assign FetchBufReadyF = ~full;
    assign FetchBufCountD = wp - rp;

`ifdef FETCH_BUFFER_PERF_EN
    logic [PERF_CNT_W-1:0] starveCnt;
    logic [PERF_CNT_W-1:0] fullCnt;

    // Saturating counters; flush deliberately leaves them untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starveCnt <= '0;
            fullCnt   <= '0;
        end else begin
            if (empty && !StallD && !FlushD && (starveCnt != '1)) begin
                starveCnt <= starveCnt + PERF_CNT_W'(1);
            end
            if (full && InstrValidF && (fullCnt != '1)) begin
                fullCnt <= fullCnt + PERF_CNT_W'(1);
            end
        end
    end

    assign FetchBufStarveCnt = starveCnt;
    assign FetchBufFullCnt   = fullCnt;
`endif

endmodule
